// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared owner encoding, FIFO entry layout and arbiter FSM states.
package imem_arbiter_pkg;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD_A = 2'b01,
        HOLD_B = 2'b10
    } state_e;

    typedef struct packed {
        logic discard;
        logic owner;
    } fifo_entry_t;

endpackage

// File: rtl/imem_arbiter_owner_fifo.sv
// imem_arbiter_owner_fifo: in-order owner tags of outstanding reads, with a parallel
// "discard all A entries" operation used when the fetch stage flushes.
module imem_arbiter_owner_fifo
    import imem_arbiter_pkg::*;
#(
    parameter int MAXOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        push_owner,
    input  logic        pop,
    input  logic        flush_a,
    output logic        full,
    output logic        empty,
    output fifo_entry_t head
);
    localparam int PW = $clog2(MAXOUT);
    localparam int CW = PW + 1;

    fifo_entry_t r_mem [MAXOUT];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    assign full  = r_count == CW'(MAXOUT);
    assign empty = r_count == '0;
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < MAXOUT; i++)
                if (flush_a && r_mem[i].owner == OWN_A) r_mem[i].discard <= 1'b1;
            // the pushed entry post-dates the flush, so it overrides the marking above
            if (push) r_mem[r_wr_ptr] <= '{discard: 1'b0, owner: push_owner};
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop) r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of the instruction-memory port between fetch (A)
// and store/debug (B), with in-order routing of read responses to their owner.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int IDATAW = 128,
    parameter int ISIZEW = 8,
    parameter int IADDRW = 32,
    parameter int MAXOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [IADDRW-1:0] a_address,
    input  logic              a_wr_en,
    input  logic [IDATAW-1:0] a_wr_data,
    input  logic [ISIZEW-1:0] a_wr_size,
    output logic              a_dp_valid,
    input  logic              a_dp_ready,
    output logic [IDATAW-1:0] a_dp_read_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [IADDRW-1:0] b_address,
    input  logic              b_wr_en,
    input  logic [IDATAW-1:0] b_wr_data,
    input  logic [ISIZEW-1:0] b_wr_size,
    output logic              b_dp_valid,
    input  logic              b_dp_ready,
    output logic [IDATAW-1:0] b_dp_read_data,
    input  logic              flush_a,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [IADDRW-1:0] m_address,
    output logic              m_wr_en,
    output logic [IDATAW-1:0] m_wr_data,
    output logic [ISIZEW-1:0] m_wr_size,
    input  logic              m_dp_valid,
    output logic              m_dp_ready,
    input  logic [IDATAW-1:0] m_dp_read_data,
    output logic              resp_err
);
    state_e      r_state;
    state_e      w_next;
    logic        r_last;
    logic        r_resp_err;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_can_rd;
    logic        w_elig_a;
    logic        w_elig_b;
    logic        w_gnt_b;
    logic        w_sel_valid;
    logic        w_xfer;
    logic        w_own_rdy;
    fifo_entry_t w_head;

    imem_arbiter_owner_fifo #(.MAXOUT(MAXOUT)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_owner (w_gnt_b),
        .pop        (w_pop),
        .flush_a    (flush_a),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head)
    );

    // a pop in this cycle frees a slot for a read accepted on the same edge
    assign w_own_rdy = w_head.owner == OWN_A ? a_dp_ready : b_dp_ready;
    assign w_pop     = reset & !w_empty & m_dp_valid & (w_head.discard | w_own_rdy);
    assign w_can_rd  = !w_full | w_pop;
    assign w_elig_a  = a_valid & (a_wr_en | w_can_rd);
    assign w_elig_b  = b_valid & (b_wr_en | w_can_rd);

    assign w_gnt_b = (r_state == HOLD_B) |
                     ((r_state == IDLE) & w_elig_b & (!w_elig_a | r_last == OWN_A));

    assign m_address   = w_gnt_b ? b_address : a_address;
    assign m_wr_en     = w_gnt_b ? b_wr_en   : a_wr_en;
    assign m_wr_data   = w_gnt_b ? b_wr_data : a_wr_data;
    assign m_wr_size   = w_gnt_b ? b_wr_size : a_wr_size;
    assign w_sel_valid = w_gnt_b ? b_valid   : a_valid;

    assign m_valid = reset & w_sel_valid & (m_wr_en | w_can_rd);
    assign w_xfer  = m_valid & m_ready;
    assign w_push  = w_xfer & !m_wr_en;
    assign a_ready = w_xfer & !w_gnt_b;
    assign b_ready = w_xfer & w_gnt_b;

    assign a_dp_valid     = reset & m_dp_valid & !w_empty & !w_head.discard & (w_head.owner == OWN_A);
    assign b_dp_valid     = reset & m_dp_valid & !w_empty & !w_head.discard & (w_head.owner == OWN_B);
    assign m_dp_ready     = reset & !w_empty & (w_head.discard | w_own_rdy);
    assign a_dp_read_data = m_dp_read_data;
    assign b_dp_read_data = m_dp_read_data;
    assign resp_err       = r_resp_err;

    // in HOLD_x the grant already points at x, so a stalled request keeps or enters HOLD
    always_comb begin
        w_next = (m_valid & !m_ready) ? (w_gnt_b ? HOLD_B : HOLD_A) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= OWN_B;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_xfer) r_last <= w_gnt_b;
            if (m_dp_valid && w_empty) r_resp_err <= 1'b1;
        end
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters.
  - Port A: fetch stage, read stream.
  - Port B: store/self-modifying-code write path, plus debug reads.
- Arbitrates requests round-robin and holds each grant until the memory accepts it.
- Tracks outstanding reads in an in-order owner FIFO and routes each read response back to its owner.
- Sits between the fetch stage / store path and the imem wrapper; supports discarding stale fetch responses on flush.

Parameters:
IDATAW, 128, memory data width
ISIZEW, 8, write size field width
IADDRW, 32, address width
MAXOUT, 4, max outstanding reads (power of 2, 2..16)

Ports:
clk  in  1  clock
reset  in  1  one clock; reset is asynchronous and active-low
a_valid / b_valid  in  1  request valid, per port
a_ready / b_ready  out  1  request accepted, per port
a_address / b_address  in  IADDRW  request address
a_wr_en / b_wr_en  in  1  1=write (no response), 0=read
a_wr_data / b_wr_data  in  IDATAW  write data
a_wr_size / b_wr_size  in  ISIZEW  write size
a_dp_valid / b_dp_valid  out  1  read response valid to owner
a_dp_ready / b_dp_ready  in  1  owner accepts response
a_dp_read_data / b_dp_read_data  out  IDATAW  response data (broadcast of m_dp_read_data)
flush_a  in  1  discard all outstanding A reads
m_valid  out  1  request to memory
m_ready  in  1  memory accepts request
m_address  out  IADDRW  selected address
m_wr_en  out  1  selected write enable
m_wr_data  out  IDATAW  selected write data
m_wr_size  out  ISIZEW  selected write size
m_dp_valid  in  1  memory response valid
m_dp_ready  out  1  response consumed
m_dp_read_data  in  IDATAW  memory response data
resp_err  out  1  sticky: response arrived with FIFO empty

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, FIFO empty, last_winner=B (A wins first tie), resp_err=0.
  - All of m_valid, a_ready, b_ready, a_dp_valid, b_dp_valid and m_dp_ready read 0 while in reset.
- Request path is zero-latency combinational from the selected port.
  - m_* mux the granted port.
  - m_valid = granted port valid.
  - x_ready = grant_x & m_ready & can_issue.
- can_issue: always 1 for writes; for reads, 1 only when FIFO is not full.
  - A read from a full FIFO is not presented: m_valid=0 for it.
  - The other port may be granted in that cycle if it has a write.
- FSM states: IDLE, HOLD_A, HOLD_B.
  - IDLE, one requester eligible: it wins.
  - IDLE, both eligible: winner = !last_winner.
  - If the winner's m_valid=1 and m_ready=0: go to HOLD_winner.
  - HOLD_x: grant stays on x regardless of the other port. Address/data must not switch under a pending request.
  - HOLD_x, m_ready=1: transfer completes; last_winner=x, return to IDLE.
  - Transfer in IDLE: last_winner updates, FSM stays IDLE.
  - x_valid dropping in HOLD_x is a protocol violation; the FSM returns to IDLE.
- Accepted read: push {owner, discard=0} into the FIFO (depth MAXOUT) on the same edge. Writes push nothing.
- Response routing (head entry h, FIFO non-empty):
  - h.discard=1: m_dp_ready=1, no x_dp_valid, pop on m_dp_valid.
  - Else x_dp_valid = m_dp_valid & (h.owner==x); m_dp_ready = owner's dp_ready; pop on m_dp_valid & m_dp_ready.
- Empty FIFO with m_dp_valid=1: m_dp_ready=0, resp_err set (cleared only by reset).
- flush_a=1: every current FIFO entry with owner A gets discard=1 at the edge.
  - An A read accepted in the same cycle is pushed with discard=0 (it post-dates the flush).
  - A head entry popped in the same cycle is unaffected.
- Simultaneous push and pop on a full FIFO is allowed only if the pop frees space first.
  - can_issue uses full & !pop_this_cycle. Occupancy is unchanged.
- Pointers wrap modulo MAXOUT; count width is clog2(MAXOUT)+1.

Decomposition:
- Shared package: owner encoding (OWN_A=0, OWN_B=1), FSM state encodings (IDLE=2'b00, HOLD_A=2'b01, HOLD_B=2'b10).
- Sub-module owner_fifo holds 2-bit entries {discard, owner} and provides:
  - push, pop, full, empty, head;
  - flush_a, which sets discard on all A entries in parallel.
- The arbiter FSM and muxes stay in imem_arbiter.

Test Plan:
- Both ports issue reads with m_ready=1 after reset -> grant order A,B,A,B; FIFO holds owners A,B,A,B; responses D0..D3 go to a,b,a,b.
- A read, m_ready=0 for 3 cycles, b_valid=1 throughout -> m_address stays a_address (0x1000) all cycles; A accepted on cycle 4; B granted on cycle 5.
- MAXOUT=4 A reads outstanding, no responses -> a_ready=0, m_valid=0; a B write (b_wr_en=1) is still accepted; FIFO count stays 4.
- 3 A reads outstanding, flush_a pulse, a new A read to 0x2000 in the same cycle -> first 3 responses consumed with a_dp_valid=0; 4th response delivered with a_dp_valid=1.
- Head owner B with b_dp_ready=0 and m_dp_valid=1 for 2 cycles -> m_dp_ready=0, no pop; pop when b_dp_ready=1.
- m_dp_valid=1 with FIFO empty -> resp_err=1 and stays 1 until reset is asserted low; asserting reset mid-burst clears FIFO, FSM and all valids immediately.
